// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_pkg
// Description : Shared definitions for the unified memory arbiter: memory
//               map defaults, sequencer state encoding and requester ids.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_pkg;

  // Byte address of memory word 0 and depth in 32-bit words
  localparam logic [31:0] MEM_BASE_ADDR = 32'h0040_0000;
  localparam int unsigned MEM_DEPTH     = 64;

  // Sequencer phases
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_e;

  // Requester identity
  typedef enum logic {
    REQ_IF = 1'b0,
    REQ_D  = 1'b1
  } req_id_e;

endpackage : mem_pkg
`default_nettype wire

// File: rtl/mem_addr_check.sv
`default_nettype none
// ============================================================================
// Module      : mem_addr_check
// Description : Combinational legality check of a byte address against the
//               memory window [BASE_ADDR, BASE_ADDR+4*DEPTH) plus word
//               alignment. The window end is formed in 33 bits so a window
//               touching the top of the address space cannot wrap.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_addr_check
  import mem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = MEM_BASE_ADDR,
  parameter int unsigned DEPTH     = MEM_DEPTH
) (
  input  logic [31:0] addr,
  output logic        legal
);

  localparam logic [32:0] c_lo = {1'b0, BASE_ADDR};
  localparam logic [32:0] c_hi = c_lo + (33'(DEPTH) << 2);

  logic [32:0] w_addr33;
  logic        w_in_range;
  logic        w_aligned;

  assign w_addr33   = {1'b0, addr};
  assign w_in_range = (w_addr33 >= c_lo) && (w_addr33 < c_hi);
  assign w_aligned  = (addr[1:0] == 2'b00);

  // A legal access is inside the window and word aligned
  always_comb begin
    legal = w_in_range && w_aligned;
  end

endmodule : mem_addr_check
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Shares the single port of the unified instruction/data memory
//               between the fetch requester and the load/store requester.
//               Each accepted request gets a one-cycle grant, at most one
//               memory strobe (legal accesses only) and a one-cycle response
//               carrying registered read data or an error flag.
//               Optional macro MEM_ARB_RR_EN: round-robin arbitration on a
//               tie (default build: data always wins a tie).
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter
  import mem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = MEM_BASE_ADDR,
  parameter int unsigned DEPTH     = MEM_DEPTH
) (
  input  logic        clk,
  input  logic        rst_n,
  // fetch requester
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  output logic        if_err,
  // load/store requester
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        d_err,
  // memory port
  output logic [31:0] mem_dir,
  output logic [31:0] mem_wdata,
  output logic        mem_rd,
  output logic        mem_wd,
  input  logic [31:0] mem_rdata
);

  // --------------------------------------------------------------------------
  // State. state_q names the phase whose registered outputs are being
  // prepared this cycle: ACCESS computes the strobe that is driven during the
  // following cycle, RESP captures mem_rdata while that strobe is on the bus
  // and builds the response driven the cycle after.
  // --------------------------------------------------------------------------
  arb_state_e  state_q,     state_d;
  req_id_e     winner_q,    winner_d;
  logic [31:0] addr_q,      addr_d;
  logic        we_q,        we_d;
  logic [31:0] wdata_q,     wdata_d;
  logic        legal_q,     legal_d;

  logic        if_gnt_q,    if_gnt_d;
  logic        d_gnt_q,     d_gnt_d;
  logic        if_rvalid_q, if_rvalid_d;
  logic        d_rvalid_q,  d_rvalid_d;
  logic [31:0] if_rdata_q,  if_rdata_d;
  logic [31:0] d_rdata_q,   d_rdata_d;
  logic        if_err_q,    if_err_d;
  logic        d_err_q,     d_err_d;
  logic [31:0] mem_dir_q,   mem_dir_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        mem_rd_q,    mem_rd_d;
  logic        mem_wd_q,    mem_wd_d;

`ifdef MEM_ARB_RR_EN
  req_id_e     last_q,      last_d;
`endif

  req_id_e     w_win;
  logic [31:0] w_sel_addr;
  logic        w_legal;
  logic [31:0] w_resp_data;

  // Pick the winner among the currently asserted requests
  always_comb begin
    w_win = REQ_IF;
`ifdef MEM_ARB_RR_EN
    if (if_req && d_req) begin
      w_win = (last_q == REQ_D) ? REQ_IF : REQ_D;
    end else if (d_req) begin
      w_win = REQ_D;
    end
`else
    if (d_req) begin
      w_win = REQ_D;
    end
`endif
    w_sel_addr = (w_win == REQ_D) ? d_addr : if_addr;
  end

  mem_addr_check #(
    .BASE_ADDR (BASE_ADDR),
    .DEPTH     (DEPTH)
  ) u_addr_check (
    .addr  (w_sel_addr),
    .legal (w_legal)
  );

  // Response payload: read data only for a legal load or fetch
  always_comb begin
    w_resp_data = (legal_q && !we_q) ? mem_rdata : 32'h0;
  end

  // Next-state and registered-output computation
  always_comb begin
    state_d     = state_q;
    winner_d    = winner_q;
    addr_d      = addr_q;
    we_d        = we_q;
    wdata_d     = wdata_q;
    legal_d     = legal_q;
    if_gnt_d    = 1'b0;
    d_gnt_d     = 1'b0;
    if_rvalid_d = 1'b0;
    d_rvalid_d  = 1'b0;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    if_err_d    = 1'b0;
    d_err_d     = 1'b0;
    mem_dir_d   = mem_dir_q;
    mem_wdata_d = mem_wdata_q;
    mem_rd_d    = 1'b0;
    mem_wd_d    = 1'b0;
`ifdef MEM_ARB_RR_EN
    last_d      = last_q;
`endif

    case (state_q)
      IDLE: begin
        if (if_req || d_req) begin
          winner_d = w_win;
          addr_d   = w_sel_addr;
          legal_d  = w_legal;
          if (w_win == REQ_D) begin
            we_d    = d_we;
            wdata_d = d_wdata;
            d_gnt_d = 1'b1;
          end else begin
            we_d     = 1'b0;
            if_gnt_d = 1'b1;
          end
`ifdef MEM_ARB_RR_EN
          last_d = w_win;
`endif
          // Illegal requests never reach the memory port
          state_d = w_legal ? ACCESS : RESP;
        end
      end

      ACCESS: begin
        mem_dir_d   = addr_q;
        mem_wdata_d = wdata_q;
        mem_rd_d    = !we_q;
        mem_wd_d    = we_q;
        state_d     = RESP;
      end

      RESP: begin
        if (winner_q == REQ_D) begin
          d_rvalid_d = 1'b1;
          d_rdata_d  = w_resp_data;
          d_err_d    = !legal_q;
        end else begin
          if_rvalid_d = 1'b1;
          if_rdata_d  = w_resp_data;
          if_err_d    = !legal_q;
        end
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      winner_q    <= REQ_D;
      addr_q      <= 32'h0;
      we_q        <= 1'b0;
      wdata_q     <= 32'h0;
      legal_q     <= 1'b0;
      if_gnt_q    <= 1'b0;
      d_gnt_q     <= 1'b0;
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      if_rdata_q  <= 32'h0;
      d_rdata_q   <= 32'h0;
      if_err_q    <= 1'b0;
      d_err_q     <= 1'b0;
      mem_dir_q   <= 32'h0;
      mem_wdata_q <= 32'h0;
      mem_rd_q    <= 1'b0;
      mem_wd_q    <= 1'b0;
`ifdef MEM_ARB_RR_EN
      last_q      <= REQ_D;
`endif
    end else begin
      state_q     <= state_d;
      winner_q    <= winner_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      wdata_q     <= wdata_d;
      legal_q     <= legal_d;
      if_gnt_q    <= if_gnt_d;
      d_gnt_q     <= d_gnt_d;
      if_rvalid_q <= if_rvalid_d;
      d_rvalid_q  <= d_rvalid_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      if_err_q    <= if_err_d;
      d_err_q     <= d_err_d;
      mem_dir_q   <= mem_dir_d;
      mem_wdata_q <= mem_wdata_d;
      mem_rd_q    <= mem_rd_d;
      mem_wd_q    <= mem_wd_d;
`ifdef MEM_ARB_RR_EN
      last_q      <= last_d;
`endif
    end
  end

  assign if_gnt    = if_gnt_q;
  assign if_rvalid = if_rvalid_q;
  assign if_rdata  = if_rdata_q;
  assign if_err    = if_err_q;
  assign d_gnt     = d_gnt_q;
  assign d_rvalid  = d_rvalid_q;
  assign d_rdata   = d_rdata_q;
  assign d_err     = d_err_q;
  assign mem_dir   = mem_dir_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_rd    = mem_rd_q;
  assign mem_wd    = mem_wd_q;

endmodule : mem_arbiter
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Scoreboard bench for mem_arbiter. Driver tasks issue fetch and
//               load/store requests; a monitor models acceptance, ordering,
//               memory contents and response timing, and compares every
//               grant, strobe and response against that model.
//               Honours MEM_ARB_RR_EN for the tie-break rule.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;
  import mem_pkg::*;

  localparam logic [31:0] BASE  = 32'h0040_0000;
  localparam int          DEPTH = 64;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req, if_gnt, if_rvalid, if_err;
  logic [31:0] if_addr, if_rdata;
  logic        d_req, d_we, d_gnt, d_rvalid, d_err;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic [31:0] mem_dir, mem_wdata, mem_rdata;
  logic        mem_rd, mem_wd;

  always #5 clk = ~clk;

  mem_arbiter #(.BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_err(if_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .mem_dir(mem_dir), .mem_wdata(mem_wdata), .mem_rd(mem_rd),
    .mem_wd(mem_wd), .mem_rdata(mem_rdata)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model state ----------------
  logic [31:0] ref_mem [DEPTH];
  logic        do_load;

  // Physical memory: combinational read, write on the strobe cycle's edge
  logic [31:0] phys_mem [DEPTH];
  logic [5:0]  phys_idx;
  assign phys_idx  = 6'((mem_dir - BASE) >> 2);
  assign mem_rdata = phys_mem[phys_idx];
  always @(posedge clk) begin
    if (do_load) begin
      for (int i = 0; i < DEPTH; i++) phys_mem[i] <= ref_mem[i];
    end else if (mem_wd) begin
      phys_mem[phys_idx] <= mem_wdata;
    end
  end

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          due;
  } exp_t;

  exp_t    q_if[$];
  exp_t    q_d[$];
  int      cyc = 0;
  bit      in_flight = 0;
  int      cur_due = 0;
  bit      st_pend = 0;
  int      st_cyc = 0;
  logic    st_we = 1'b0;
  logic [31:0] st_addr = '0, st_wdata = '0;
  req_id_e last_win = REQ_D;

  function automatic bit addr_legal(input logic [31:0] a);
    longint v = longint'(a);
    return (v >= longint'(BASE)) && (v < longint'(BASE) + 4 * DEPTH) && (v % 4 == 0);
  endfunction

  // Monitor / scoreboard, samples 1 time unit after each rising edge
  initial begin
    exp_t    e;
    req_id_e who, exp_who;
    logic [31:0] a, wd;
    logic    we, lg, gnt_any, exp_gnt;
    int      idx;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = $urandom;
    ref_mem[1] = 32'h14AA0004;
    forever begin
      @(posedge clk); #1;
      cyc++;
      if (!rst_n) begin
        q_if.delete(); q_d.delete();
        in_flight = 0; st_pend = 0; last_win = REQ_D;
        check("reset_ctrl", {24'h0, if_gnt, d_gnt, if_rvalid, d_rvalid, if_err, d_err, mem_rd, mem_wd}, 32'h0);
        check("reset_if_rdata", if_rdata, 32'h0);
        check("reset_d_rdata", d_rdata, 32'h0);
        check("reset_mem_dir", mem_dir, 32'h0);
        check("reset_mem_wdata", mem_wdata, 32'h0);
        continue;
      end

      // Strobe: exactly one cycle after the grant of a legal access, else none
      if (st_pend && cyc == st_cyc) begin
        check("strobe_rd", {31'h0, mem_rd}, {31'h0, !st_we});
        check("strobe_wd", {31'h0, mem_wd}, {31'h0, st_we});
        check("strobe_dir", mem_dir, st_addr);
        if (st_we) check("strobe_wdata", mem_wdata, st_wdata);
        st_pend = 0;
      end else begin
        check("no_strobe", {30'h0, mem_rd, mem_wd}, 32'h0);
      end

      // Responses
      if (if_rvalid) begin
        if (q_if.size() == 0) check("if_rvalid_unexpected", 32'h1, 32'h0);
        else begin
          e = q_if.pop_front();
          check("if_rdata", if_rdata, e.rdata);
          check("if_err", {31'h0, if_err}, {31'h0, e.err});
          check("if_rvalid_cycle", cyc, e.due);
        end
      end
      if (d_rvalid) begin
        if (q_d.size() == 0) check("d_rvalid_unexpected", 32'h1, 32'h0);
        else begin
          e = q_d.pop_front();
          check("d_rdata", d_rdata, e.rdata);
          check("d_err", {31'h0, d_err}, {31'h0, e.err});
          check("d_rvalid_cycle", cyc, e.due);
        end
      end
      if (in_flight && (if_rvalid || d_rvalid || cyc > cur_due)) begin
        if (!(if_rvalid || d_rvalid)) check("rvalid_missing", 32'h0, 32'h1);
        in_flight = 0;
        q_if.delete(); q_d.delete();
        continue;
      end

      // Grants: one per idle arbitration, none while a transaction is open
      check("gnt_exclusive", {31'h0, if_gnt && d_gnt}, 32'h0);
      gnt_any = if_gnt || d_gnt;
      exp_gnt = !in_flight && (if_req || d_req);
      check("gnt_timing", {31'h0, gnt_any}, {31'h0, exp_gnt});
      if (gnt_any && !in_flight) begin
        who = d_gnt ? REQ_D : REQ_IF;
        if (if_req && d_req) begin
`ifdef MEM_ARB_RR_EN
          exp_who = (last_win == REQ_D) ? REQ_IF : REQ_D;
`else
          exp_who = REQ_D;
`endif
          check("tie_winner", {31'h0, who}, {31'h0, exp_who});
        end
        last_win = who;
        a  = (who == REQ_D) ? d_addr : if_addr;
        we = (who == REQ_D) ? d_we : 1'b0;
        wd = d_wdata;
        lg = addr_legal(a);
        e.err   = !lg;
        e.rdata = 32'h0;
        e.due   = cyc + (lg ? 2 : 1);
        if (lg) begin
          idx = int'((a - BASE) / 4);
          if (we) ref_mem[idx] = wd;
          else    e.rdata = ref_mem[idx];
          st_pend = 1; st_cyc = cyc + 1; st_we = we; st_addr = a; st_wdata = wd;
        end
        if (who == REQ_D) q_d.push_back(e); else q_if.push_back(e);
        in_flight = 1;
        cur_due = e.due;
      end
    end
  end

  // ---------------- drivers (called at a falling edge) ----------------
  task automatic do_fetch(input logic [31:0] a);
    int n = 0;
    if_req = 1'b1; if_addr = a;
    do begin @(negedge clk); n++; end while (!if_gnt && n < 200);
    check("if_gnt_wait", {31'h0, if_gnt}, 32'h1);
    if_req = 1'b0;
  endtask

  task automatic do_data(input logic we, input logic [31:0] a, input logic [31:0] wd);
    int n = 0;
    d_req = 1'b1; d_we = we; d_addr = a; d_wdata = wd;
    do begin @(negedge clk); n++; end while (!d_gnt && n < 200);
    check("d_gnt_wait", {31'h0, d_gnt}, 32'h1);
    d_req = 1'b0;
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 5))
      0:       return 32'($urandom);
      1:       return BASE - 32'(4 * $urandom_range(1, 4));
      2:       return BASE + 32'(4 * DEPTH) + 32'(4 * $urandom_range(0, 3));
      3:       return BASE + 32'(4 * $urandom_range(0, DEPTH - 1)) + 32'($urandom_range(1, 3));
      default: return BASE + 32'(4 * $urandom_range(0, DEPTH - 1));
    endcase
  endfunction

  task automatic drain();
    int n = 0;
    while ((in_flight || q_if.size() != 0 || q_d.size() != 0) && n < 50) begin
      @(negedge clk); n++;
    end
    check("drain", {31'h0, in_flight}, 32'h0);
    repeat (2) @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0; do_load = 1'b1;
    if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    repeat (3) @(negedge clk);
    do_load = 1'b0; rst_n = 1'b1;

    // directed: fetch, store/load, illegal loads
    do_fetch(32'h0040_0004);
    do_data(1'b1, 32'h0040_0018, 32'hDEAD_BEEF);
    do_data(1'b0, 32'h0040_0018, 32'h0);
    do_data(1'b0, 32'h003F_FFFC, 32'h0);
    do_data(1'b0, 32'h0040_0100, 32'h0);
    do_data(1'b0, 32'h0040_0002, 32'h0);
    drain();

    // simultaneous requests, then continuous competing streams
    fork
      begin for (int i = 0; i < 6; i++) do_fetch(BASE + 32'(4 * i)); end
      begin for (int i = 0; i < 6; i++) do_data(1'(i % 2), BASE + 32'(4 * (i + 8)), $urandom); end
    join
    drain();

    // randomized mixed traffic with idle gaps
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          repeat ($urandom_range(0, 3)) @(negedge clk);
          do_fetch(rand_addr());
        end
      end
      begin
        for (int i = 0; i < 40; i++) begin
          repeat ($urandom_range(0, 3)) @(negedge clk);
          do_data(1'($urandom_range(0, 1)), rand_addr(), $urandom);
        end
      end
    join
    drain();

    // reset during the strobe cycle of a load: the response must never appear
    do_data(1'b0, 32'h0040_0020, 32'h0);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    // traffic still works after the mid-transaction reset
    fork
      do_fetch(32'h0040_0004);
      do_data(1'b0, 32'h0040_0018, 32'h0);
    join
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_mem_arbiter
`default_nettype wire
